// File: rtl/vga_timing_generator.sv
// VGA timing generator: horizontal/vertical region FSMs, per-pixel fetch requests and a 2-stage pixel/sync output pipeline.
// Optional line-compare interrupt is built when VGA_TIMING_LINE_IRQ_EN is defined.
module vga_timing_generator #(
  parameter int H_VISIBLE = 100,
  parameter int H_FRONT   = 5,
  parameter int H_SYNC    = 16,
  parameter int H_BACK    = 11,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter int COUNT_W   = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               enable,
  output logic               pixel_req,
  output logic [COUNT_W-1:0] pixel_x,
  output logic [COUNT_W-1:0] pixel_y,
  input  logic [5:0]         pixel_data,
  input  logic               pixel_valid,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic [5:0]         vga_pixel,
  output logic               frame_start,
  output logic               underflow,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [COUNT_W-1:0] line_compare,
  output logic               line_irq,
`endif
  input  logic               clear_underflow
);

  typedef enum logic [1:0] {HS_VIS, HS_FP, HS_SYNC, HS_BACK} h_state_t;
  typedef enum logic [1:0] {VS_VIS, VS_FP, VS_SYNC, VS_BACK} v_state_t;

  // Complete timing position; active marks a running cycle (one cycle behind enable).
  typedef struct packed {
    logic               active;
    h_state_t           h_state;
    logic [COUNT_W-1:0] h_cnt;
    v_state_t           v_state;
    logic [COUNT_W-1:0] v_cnt;
  } timing_state_t;

  timing_state_t      st;
  logic [COUNT_W-1:0] last_x;
  logic [COUNT_W-1:0] last_y;
  logic               h_last;
  logic               v_last;
  logic               vis;
  h_state_t           h_next;
  v_state_t           v_next;

  logic               req_d1;
  logic               hsync_d1;
  logic               vsync_d1;

  always_comb begin
    h_last = 1'b0;
    h_next = HS_VIS;
    case (st.h_state)
      HS_VIS:  begin h_last = (st.h_cnt == COUNT_W'(H_VISIBLE - 1)); h_next = HS_FP;   end
      HS_FP:   begin h_last = (st.h_cnt == COUNT_W'(H_FRONT - 1));   h_next = HS_SYNC; end
      HS_SYNC: begin h_last = (st.h_cnt == COUNT_W'(H_SYNC - 1));    h_next = HS_BACK; end
      default: begin h_last = (st.h_cnt == COUNT_W'(H_BACK - 1));    h_next = HS_VIS;  end
    endcase
  end

  always_comb begin
    v_last = 1'b0;
    v_next = VS_VIS;
    case (st.v_state)
      VS_VIS:  begin v_last = (st.v_cnt == COUNT_W'(V_VISIBLE - 1)); v_next = VS_FP;   end
      VS_FP:   begin v_last = (st.v_cnt == COUNT_W'(V_FRONT - 1));   v_next = VS_SYNC; end
      VS_SYNC: begin v_last = (st.v_cnt == COUNT_W'(V_SYNC - 1));    v_next = VS_BACK; end
      default: begin v_last = (st.v_cnt == COUNT_W'(V_BACK - 1));    v_next = VS_VIS;  end
    endcase
  end

  // Request handshake: pixel_req/pixel_x/pixel_y name a pixel in cycle N; the source answers with
  // pixel_data qualified by pixel_valid in cycle N+1. There is no back-pressure on requests.
  assign vis         = st.active && (st.h_state == HS_VIS) && (st.v_state == VS_VIS);
  assign pixel_req   = vis;
  assign pixel_x     = vis ? st.h_cnt : last_x;
  assign pixel_y     = vis ? st.v_cnt : last_y;
  assign frame_start = vis && (st.h_cnt == '0) && (st.v_cnt == '0);

`ifdef VGA_TIMING_LINE_IRQ_EN
  assign line_irq = vis && (st.h_cnt == '0) && (st.v_cnt == line_compare);
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      st.active  <= 1'b0;
      st.h_state <= HS_VIS;
      st.h_cnt   <= '0;
      st.v_state <= VS_VIS;
      st.v_cnt   <= '0;
      last_x     <= '0;
      last_y     <= '0;
    end else begin
      st.active <= enable;
      if (!enable) begin
        st.h_state <= HS_VIS;
        st.h_cnt   <= '0;
        st.v_state <= VS_VIS;
        st.v_cnt   <= '0;
        last_x     <= '0;
        last_y     <= '0;
      end else if (st.active) begin
        if (vis) begin
          last_x <= st.h_cnt;
          last_y <= st.v_cnt;
        end
        if (h_last) begin
          st.h_cnt   <= '0;
          st.h_state <= h_next;
          // Vertical position moves only at the line boundary so vsync edges align with H_VIS.
          if (st.h_state == HS_BACK) begin
            if (v_last) begin
              st.v_cnt   <= '0;
              st.v_state <= v_next;
            end else begin
              st.v_cnt <= st.v_cnt + 1'b1;
            end
          end
        end else begin
          st.h_cnt <= st.h_cnt + 1'b1;
        end
      end
    end
  end

  // Stage 1 carries request and sync state alongside the source latency; stage 2 drives the pins.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      req_d1    <= 1'b0;
      hsync_d1  <= 1'b1;
      vsync_d1  <= 1'b1;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_pixel <= 6'd0;
      underflow <= 1'b0;
    end else begin
      req_d1    <= pixel_req;
      hsync_d1  <= !(st.active && (st.h_state == HS_SYNC));
      vsync_d1  <= !(st.active && (st.v_state == VS_SYNC));
      vga_hsync <= hsync_d1;
      vga_vsync <= vsync_d1;
      vga_pixel <= (req_d1 && pixel_valid) ? pixel_data : 6'd0;
      if (req_d1 && !pixel_valid) begin
        underflow <= 1'b1;
      end else if (clear_underflow) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a reduced frame height (40 visible lines) with default horizontal timing;
// the source answers each request with pixel_x[5:0] one cycle later.
module tb_vga_timing_generator;
  localparam int HT = 132;
  localparam int VV = 40;
  localparam int VT = VV + 1 + 4 + 23;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       pixel_valid = 1'b1;
  logic       clear_underflow = 1'b0;
  logic [5:0] pixel_data = 6'd0;
  logic       pixel_req;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       vga_hsync;
  logic       vga_vsync;
  logic [5:0] vga_pixel;
  logic       frame_start;
  logic       underflow;
`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [9:0] line_compare = 10'd10;
  logic       line_irq;
`endif

  vga_timing_generator #(.V_VISIBLE(VV)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .enable(enable),
    .pixel_req(pixel_req),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_pixel(vga_pixel),
    .frame_start(frame_start),
    .underflow(underflow),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .line_compare(line_compare),
    .line_irq(line_irq),
`endif
    .clear_underflow(clear_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [5:0] pix;
    logic       uf;
  } vec_t;

  vec_t       tbl[$];
  int         errors = 0;
  int         checks = 0;
  logic [5:0] src_q = 6'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: present last cycle's fetch result, then sample outputs 2 time units after the edge.
  task automatic tick(input logic drop, input logic clr);
    @(posedge clk);
    #1;
    pixel_data      = src_q;
    pixel_valid     = !drop;
    clear_underflow = clr;
    src_q           = pixel_x[5:0];
    #1;
  endtask

  task automatic add(input int t, input logic req, input int x, input int y, input logic fs,
                     input logic hs, input logic vs, input int pix, input logic uf);
    vec_t v;
    v.t = t; v.req = req; v.x = 10'(x); v.y = 10'(y); v.fs = fs;
    v.hs = hs; v.vs = vs; v.pix = 6'(pix); v.uf = uf;
    tbl.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v);
    chk($sformatf("t%0d_req", v.t), 32'(pixel_req), 32'(v.req));
    chk($sformatf("t%0d_x", v.t), 32'(pixel_x), 32'(v.x));
    chk($sformatf("t%0d_y", v.t), 32'(pixel_y), 32'(v.y));
    chk($sformatf("t%0d_fs", v.t), 32'(frame_start), 32'(v.fs));
    chk($sformatf("t%0d_hs", v.t), 32'(vga_hsync), 32'(v.hs));
    chk($sformatf("t%0d_vs", v.t), 32'(vga_vsync), 32'(v.vs));
    chk($sformatf("t%0d_pix", v.t), 32'(vga_pixel), 32'(v.pix));
    chk($sformatf("t%0d_uf", v.t), 32'(underflow), 32'(v.uf));
  endtask

  function automatic logic m_vis(input int c);
    int l = (c / HT) % VT;
    int x = c % HT;
    return (l < VV) && (x < 100);
  endfunction

  function automatic logic [5:0] m_pix(input int c);
    if (c < 2) return 6'd0;
    if (!m_vis(c - 2)) return 6'd0;
    return 6'((c - 2) % HT);
  endfunction

  function automatic logic m_hs(input int c);
    int x;
    if (c < 2) return 1'b1;
    x = (c - 2) % HT;
    return !(x >= 105 && x <= 120);
  endfunction

  function automatic logic m_vs(input int c);
    int l;
    if (c < 2) return 1'b1;
    l = ((c - 2) / HT) % VT;
    return !(l >= 41 && l <= 44);
  endfunction

  initial begin
    int req_bad = 0, hs_bad = 0, vs_bad = 0, pix_bad = 0;
    int hs_low = 0, vs_low = 0, req_cnt = 0, fs_cnt = 0, fs_gap = -1;
    int irq_cnt = 0, irq_t = -1;

    //  t     req x   y   fs hs vs pix uf
    add(0,    1,  0,  0,  1, 1, 1, 0,  0);
    add(1,    1,  1,  0,  0, 1, 1, 0,  0);
    add(2,    1,  2,  0,  0, 1, 1, 0,  0);
    add(3,    1,  3,  0,  0, 1, 1, 1,  0);
    add(99,   1,  99, 0,  0, 1, 1, 33, 0);
    add(100,  0,  99, 0,  0, 1, 1, 34, 0);
    add(101,  0,  99, 0,  0, 1, 1, 35, 0);
    add(102,  0,  99, 0,  0, 1, 1, 0,  0);
    add(106,  0,  99, 0,  0, 1, 1, 0,  0);
    add(107,  0,  99, 0,  0, 0, 1, 0,  0);
    add(122,  0,  99, 0,  0, 0, 1, 0,  0);
    add(123,  0,  99, 0,  0, 1, 1, 0,  0);
    add(132,  1,  0,  1,  0, 1, 1, 0,  0);
    add(135,  1,  3,  1,  0, 1, 1, 1,  0);
    add(1320, 1,  0,  10, 0, 1, 1, 0,  0);
    add(5148, 1,  0,  39, 0, 1, 1, 0,  0);
    add(5280, 0,  99, 39, 0, 1, 1, 0,  0);
    add(5413, 0,  99, 39, 0, 1, 1, 0,  0);
    add(5414, 0,  99, 39, 0, 1, 0, 0,  0);
    add(5941, 0,  99, 39, 0, 1, 0, 0,  0);
    add(5942, 0,  99, 39, 0, 1, 1, 0,  0);
    add(8975, 0,  99, 39, 0, 1, 1, 0,  0);
    add(8976, 1,  0,  0,  1, 1, 1, 0,  0);
    add(8978, 1,  2,  0,  0, 1, 1, 0,  0);
    add(9647, 1,  11, 5,  0, 1, 1, 9,  0);
    add(9648, 1,  12, 5,  0, 1, 1, 0,  1);
    add(9649, 1,  13, 5,  0, 1, 1, 11, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(pixel_req), 32'd0);
    chk("rst_x", 32'(pixel_x), 32'd0);
    chk("rst_y", 32'(pixel_y), 32'd0);
    chk("rst_hs", 32'(vga_hsync), 32'd1);
    chk("rst_vs", 32'(vga_vsync), 32'd1);
    chk("rst_pix", 32'(vga_pixel), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Main run: one full frame plus the start of the next, with one dropped fetch at (10,5).
    for (int i = 0; i < 9700; i++) begin
      tick(1'(i == 9647), 1'b0);
      if (pixel_req !== m_vis(i)) req_bad++;
      if (vga_hsync !== m_hs(i)) hs_bad++;
      if (vga_vsync !== m_vs(i)) vs_bad++;
      if (vga_pixel !== ((i == 9648) ? 6'd0 : m_pix(i))) pix_bad++;
      if (i < FT) begin
        if (!vga_hsync) hs_low++;
        if (!vga_vsync) vs_low++;
        if (pixel_req) req_cnt++;
      end
      if (i <= FT && frame_start) fs_cnt++;
`ifdef VGA_TIMING_LINE_IRQ_EN
      if (i < FT && line_irq) begin
        irq_cnt++;
        irq_t = i;
      end
`endif
      foreach (tbl[k]) if (tbl[k].t == i) apply_vec(tbl[k]);
    end
    chk("req_stream_errs", 32'(req_bad), 32'd0);
    chk("hs_stream_errs", 32'(hs_bad), 32'd0);
    chk("vs_stream_errs", 32'(vs_bad), 32'd0);
    chk("pix_stream_errs", 32'(pix_bad), 32'd0);
    chk("hs_low_per_frame", 32'(hs_low), 32'(VT * 16));
    chk("vs_low_per_frame", 32'(vs_low), 32'(4 * HT));
    chk("req_per_frame", 32'(req_cnt), 32'(VV * 100));
    chk("fs_count", 32'(fs_cnt), 32'd2);
`ifdef VGA_TIMING_LINE_IRQ_EN
    chk("irq_count", 32'(irq_cnt), 32'd1);
    chk("irq_time", 32'(irq_t), 32'(10 * HT));
`endif

    // Underflow clear alone, set+clear together, clear alone (requests here are visible).
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("uf_cleared", 32'(underflow), 32'd0);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("uf_set_wins", 32'(underflow), 32'd1);
    chk("uf_pix_blank", 32'(vga_pixel), 32'd0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("uf_clear_again", 32'(underflow), 32'd0);

    // Enable low: counters reset next cycle, pipeline drains two cycles, then idle.
    enable = 1'b0;
    tick(1'b0, 1'b0);
    chk("dis_req", 32'(pixel_req), 32'd0);
    chk("dis_x", 32'(pixel_x), 32'd0);
    chk("dis_y", 32'(pixel_y), 32'd0);
    chk("dis_drain1", 32'(vga_pixel), 32'd4);
    tick(1'b0, 1'b0);
    chk("dis_drain2", 32'(vga_pixel), 32'd5);
    tick(1'b0, 1'b0);
    chk("dis_idle_pix", 32'(vga_pixel), 32'd0);
    chk("dis_idle_hs", 32'(vga_hsync), 32'd1);
    chk("dis_idle_vs", 32'(vga_vsync), 32'd1);
    enable = 1'b1;
    tick(1'b0, 1'b0);
    chk("en_fs", 32'(frame_start), 32'd1);
    chk("en_req", 32'(pixel_req), 32'd1);

    // Asynchronous reset mid-line at (50,30).
    for (int i = 0; i < 30 * HT + 50; i++) tick(1'b0, 1'b0);
    chk("pre_rst_x", 32'(pixel_x), 32'd50);
    chk("pre_rst_y", 32'(pixel_y), 32'd30);
    chk("pre_rst_pix", 32'(vga_pixel), 32'd48);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pix", 32'(vga_pixel), 32'd0);
    chk("arst_hs", 32'(vga_hsync), 32'd1);
    chk("arst_vs", 32'(vga_vsync), 32'd1);
    chk("arst_req", 32'(pixel_req), 32'd0);
    chk("arst_x", 32'(pixel_x), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1'b0, 1'b0);
    chk("post_rst_fs", 32'(frame_start), 32'd1);
    chk("post_rst_y", 32'(pixel_y), 32'd0);
`ifdef VGA_TIMING_LINE_IRQ_EN
    line_compare = 10'(VV);
    irq_cnt = 0;
`endif
    for (int i = 1; i <= FT + 100 && fs_gap < 0; i++) begin
      tick(1'b0, 1'b0);
      if (frame_start) fs_gap = i;
`ifdef VGA_TIMING_LINE_IRQ_EN
      if (line_irq) irq_cnt++;
`endif
    end
    chk("fs_period", 32'(fs_gap), 32'(FT));
`ifdef VGA_TIMING_LINE_IRQ_EN
    chk("irq_out_of_range", 32'(irq_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Transmit side of the video output interface: generates VGA hsync/vsync and the 6-bit pixel bus driven on mprj_io[37:30] (hsync 37, vsync 36, pixel 35:30).
- Walks horizontal and vertical counters through visible/front/sync/back regions.
- Issues per-pixel fetch requests to the video memory reader and forwards returned data, blanking outside the visible area.
- Default timing is 800x600@60 with horizontal scaled by 8, so the existing video bench's sync measurements pass at the 40 MHz sim clock.

Parameters:
H_VISIBLE, 100, visible pixels per line
H_FRONT, 5, front porch cycles
H_SYNC, 16, hsync pulse cycles
H_BACK, 11, back porch cycles
V_VISIBLE, 600, visible lines
V_FRONT, 1, front porch lines
V_SYNC, 4, vsync pulse lines
V_BACK, 23, back porch lines
COUNT_W, 10, width of pixel_x/pixel_y and internal counters

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  reset, asynchronous, active-high
enable  input  1  run timing; low holds block idle
pixel_req  output  1  fetch request for (pixel_x, pixel_y)
pixel_x  output  COUNT_W  requested column
pixel_y  output  COUNT_W  requested row
pixel_data  input  6  returned pixel, one cycle after pixel_req
pixel_valid  input  1  pixel_data valid
vga_hsync  output  1  horizontal sync, active-low
vga_vsync  output  1  vertical sync, active-low
vga_pixel  output  6  pixel output, 0 when blanked
frame_start  output  1  one-cycle pulse when request phase is at (0,0)
underflow  output  1  sticky: visible pixel had no valid data
clear_underflow  input  1  clears underflow

Behaviour:
- Reset values: all counters 0; pixel_req 0; pixel_x/pixel_y 0; vga_hsync 1; vga_vsync 1; vga_pixel 0; frame_start 0; underflow 0; pipeline flushed.
- Horizontal FSM: H_VIS -> H_FP -> H_SYNC -> H_BACK -> H_VIS; each state lasts its parameter in cycles. Line length is H_TOTAL = sum of the four, 132 by default.
- Vertical FSM: V_VIS -> V_FP -> V_SYNC -> V_BACK. Advances only on the last cycle of H_BACK. Frame length is 628 lines by default.
- Zero-length regions are illegal; behaviour is undefined.
- Stage 0 (counter cycle N):
  - pixel_req = 1 iff both FSMs are in VIS.
  - pixel_x = column within H_VIS; pixel_y = row within V_VIS.
  - Outside VIS, pixel_x and pixel_y hold their last values.
- Stage 1 (cycle N+1): the source presents pixel_data/pixel_valid for the cycle-N request.
- Stage 2 (registered at the end of N+1):
  - vga_pixel = pixel_data if the request was visible and pixel_valid; otherwise 0.
  - vga_hsync/vga_vsync are delayed 2 cycles from the FSM state so they stay aligned with vga_pixel.
- Total latency: 2 cycles from request to pin.
- hsync is low for exactly H_SYNC cycles per line on every line, including vertical blanking.
- vsync falls and rises aligned with the line boundary (H_VIS start of the delayed stream), so the vsync low time is exactly V_SYNC*H_TOTAL cycles.
- Underflow:
  - Visible request with pixel_valid=0 in stage 1: vga_pixel=0 and underflow sets.
  - clear_underflow=1 clears underflow.
  - Set and clear in the same cycle: set wins.
- enable low:
  - Counters reset to start of H_VIS/V_VIS in the next cycle.
  - pixel_req 0; the pipeline drains normally for 2 cycles, then outputs return to reset values.
- enable rising: first request is (0,0) on the following cycle, with frame_start pulsing at that cycle.
- Reset mid-frame: all outputs return to reset values immediately (async); after release the FSMs restart at (0,0) only if enable=1.
- Wrap-around: after the last cycle of V_BACK/H_BACK the next cycle is (0,0) with frame_start=1. There is no dead cycle between frames.

Optional Feature:
- Macro VGA_TIMING_LINE_IRQ_EN.
- When defined:
  - Adds input line_compare [COUNT_W-1:0] and output line_irq (1 bit).
  - line_irq pulses for one cycle at stage 0 of pixel_x=0 when pixel_y==line_compare and the FSM is in V_VIS.
  - line_compare >= V_VISIBLE never fires.
- When undefined: neither port exists and no compare logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset, enable=1, pixel_valid=1 tied, pixel_data=6'h2A -> vga_hsync low 16 cycles (400 ns) with period 132 cycles (3.3 us); vga_pixel=6'h2A for 100 consecutive cycles per visible line, 0 otherwise.
- Run a full frame -> vga_vsync low 528 cycles (13.2 us), period 82896 cycles (2072.4 us); frame_start pulses once per 82896 cycles with pixel_x=0, pixel_y=0.
- Source returns pixel_data = pixel_x[5:0] -> vga_pixel equals requested column exactly 2 cycles after pixel_req; first visible pin value 0, last 6'h23 (99).
- Drop pixel_valid for one visible request at (10,5) -> that pin pixel = 0 and underflow=1 and stays set; pulse clear_underflow together with a new underflow -> underflow remains 1; clear alone -> 0.
- Assert wb_rst_i mid-line at (50,300) -> hsync/vsync=1 and pixel=0 immediately; after release the next frame_start occurs 1 cycle later with period checks passing.
- With VGA_TIMING_LINE_IRQ_EN and line_compare=10 -> exactly one line_irq per frame, coincident with request (0,10); line_compare=600 -> none.
